// File: rtl/dac_spi_tx.sv
// dac_spi_tx: handshaked serial DAC transmitter sending one {control, sample} frame per enabled channel.
// Optional macro DAC_LDAC_EN adds an ldac_n pulse after the last channel so all channels update together.
module dac_spi_tx #(
  parameter int          DATA_W   = 8,
  parameter int          CTRL_W   = 8,
  parameter int          NUM_CH   = 2,
  parameter logic [31:0] CH_CTRL  = 32'h0000_9010,
  parameter int          CLK_DIV  = 1,
  parameter int          GAP_SCLK = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     din,
  output logic                     sync,
  output logic                     sclk
`ifdef DAC_LDAC_EN
  ,
  output logic                     ldac_n
`endif
);

  localparam int FRAME_W = CTRL_W + DATA_W;
  localparam int GAP_CYC = 2 * CLK_DIV * GAP_SCLK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W   = $clog2(GAP_CYC);
  localparam int BIT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    GAP,
`ifdef DAC_LDAC_EN
    LDAC,
`endif
    DONE
  } state_t;

  state_t                    state;
  logic [NUM_CH*DATA_W-1:0]  data_lat;
  logic [NUM_CH-1:0]         pend;
  logic [FRAME_W-1:0]        shreg;
  logic [FRAME_W-1:0]        shreg_nx;
  logic [DIV_W-1:0]          div_cnt;
  logic [BIT_W-1:0]          bit_cnt;
  logic [GAP_W-1:0]          gap_cnt;
  logic [FRAME_W-1:0]        frame_all [NUM_CH];
  logic                      have_next;
  logic [CH_W-1:0]           next_ch;
`ifdef DAC_LDAC_EN
  logic                      any_ch;
`endif

  assign shreg_nx = shreg << 1;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_frame
    if (CTRL_W > 0) begin : g_ctrl
      assign frame_all[i] = {CH_CTRL[i*CTRL_W +: CTRL_W], data_lat[i*DATA_W +: DATA_W]};
    end else begin : g_noctrl
      assign frame_all[i] = data_lat[i*DATA_W +: DATA_W];
    end
  end

  // Lowest still-pending channel; sent channels are cleared from pend.
  always_comb begin
    have_next = 1'b0;
    next_ch   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        have_next = 1'b1;
        next_ch   = CH_W'(i);
      end
    end
  end

  // An accepted start enters GAP with its counter already expired, so the first
  // frame (or the empty-mask DONE) launches one cycle later through the same path
  // as every following channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sync     <= 1'b1;
      sclk     <= 1'b1;
      din      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_lat <= '0;
      pend     <= '0;
      shreg    <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
`ifdef DAC_LDAC_EN
      any_ch   <= 1'b0;
      ldac_n   <= 1'b1;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            data_lat <= data_in;
            pend     <= ch_mask;
            busy     <= 1'b1;
            gap_cnt  <= GAP_W'(GAP_CYC - 1);
            state    <= GAP;
`ifdef DAC_LDAC_EN
            any_ch   <= |ch_mask;
`endif
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (sclk) begin
              sclk <= 1'b0;
            end else begin
              sclk <= 1'b1;
              if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
                sync    <= 1'b1;
                din     <= 1'b0;
                gap_cnt <= '0;
                state   <= GAP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= shreg_nx;
                din     <= shreg_nx[FRAME_W-1];
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
            gap_cnt <= '0;
            if (have_next) begin
              pend    <= pend & ~(NUM_CH'(1) << next_ch);
              shreg   <= frame_all[next_ch];
              din     <= frame_all[next_ch][FRAME_W-1];
              sync    <= 1'b0;
              div_cnt <= '0;
              bit_cnt <= '0;
              state   <= SHIFT;
            end
`ifdef DAC_LDAC_EN
            else if (any_ch) begin
              ldac_n <= 1'b0;
              state  <= LDAC;
            end
`endif
            else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
`ifdef DAC_LDAC_EN
        LDAC: begin
          if (gap_cnt == GAP_W'(2 * CLK_DIV - 1)) begin
            gap_cnt <= '0;
            ldac_n  <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
`endif
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: scoreboard bench; stimulus queues expected frames, negedge monitors decode the serial bus.
// Instance a uses default parameters, instance b uses CLK_DIV=3, DATA_W=12, CTRL_W=4.
module tb_dac_spi_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_a = '0;
  logic [1:0]  mask_a = '0;
  logic        start_a = 1'b0;
  logic        busy_a, done_a, din_a, sync_a, sclk_a;
  logic [23:0] data_b = '0;
  logic [1:0]  mask_b = '0;
  logic        start_b = 1'b0;
  logic        busy_b, done_b, din_b, sync_b, sclk_b;
`ifdef DAC_LDAC_EN
  logic        ldac_a, ldac_b;
`endif

  int checks = 0;
  int errors = 0;
  int exp_tot_frames = 0;
  int exp_tot_done   = 0;
  int tot_frames_a   = 0;
  int tot_done_a     = 0;
  int tot_frames_b   = 0;
  int tot_done_b     = 0;

  logic [15:0] exp_qa [$];
  int          done_qa [$];
  logic [15:0] exp_qb [$];

  always #5 clk = ~clk;

  dac_spi_tx dut_a (
    .clk(clk), .rst(rst), .data_in(data_a), .ch_mask(mask_a), .start(start_a),
    .busy(busy_a), .done(done_a), .din(din_a), .sync(sync_a), .sclk(sclk_a)
`ifdef DAC_LDAC_EN
    , .ldac_n(ldac_a)
`endif
  );

  dac_spi_tx #(.DATA_W(12), .CTRL_W(4), .NUM_CH(2), .CH_CTRL(32'h0000_00C3),
               .CLK_DIV(3), .GAP_SCLK(2)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_b), .ch_mask(mask_b), .start(start_b),
    .busy(busy_b), .done(done_b), .din(din_b), .sync(sync_b), .sclk(sclk_b)
`ifdef DAC_LDAC_EN
    , .ldac_n(ldac_b)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic flagFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got unexpected event expected none", name);
  endtask

  // Drives one transfer on instance a and queues its hand-computed frames.
  task automatic applyStimulus(input logic [15:0] data, input logic [1:0] mask,
                               input int nframes, input logic [15:0] f0, input logic [15:0] f1);
    if (nframes > 0) exp_qa.push_back(f0);
    if (nframes > 1) exp_qa.push_back(f1);
    done_qa.push_back(nframes);
    exp_tot_frames += nframes;
    exp_tot_done   += 1;
    @(negedge clk);
    data_a  = data;
    mask_a  = mask;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic waitIdleA(input string name);
    int i = 0;
    while (busy_a === 1'b1 && i < 1000) begin
      @(negedge clk);
      i++;
    end
    if (busy_a !== 1'b0) flagFail(name);
    @(negedge clk);
  endtask

  // Monitor for instance a: rebuilds each frame from sclk falls and scores it on sync rise.
  int          low_a, nb_a, since_rise_a, frames_a, ldac_cnt_a;
  logic [15:0] rx_a;
  logic        sync_aq = 1'b1, sclk_aq = 1'b1;
  int          exp_n;
  always @(negedge clk) begin
    if (rst) begin
      low_a = 0; nb_a = 0; rx_a = '0; since_rise_a = 0; frames_a = 0; ldac_cnt_a = 0;
    end else begin
      since_rise_a++;
`ifdef DAC_LDAC_EN
      if (!ldac_a) ldac_cnt_a++;
`endif
      if (!sync_a) begin
        low_a++;
        if (sclk_aq && !sclk_a) begin
          rx_a = {rx_a[14:0], din_a};
          nb_a++;
        end
      end else if (!sync_aq) begin
        checkOutput("a_sync_low_cycles", 32'(low_a), 32'd32);
        checkOutput("a_sclk_falls", 32'(nb_a), 32'd16);
        checkOutput("a_busy_in_frame", 32'(busy_a), 32'd1);
        if (exp_qa.size() == 0) flagFail("a_unexpected_frame");
        else checkOutput("a_frame_bits", 32'(rx_a), 32'(exp_qa.pop_front()));
        frames_a++; tot_frames_a++;
        low_a = 0; nb_a = 0; rx_a = '0; since_rise_a = 0;
      end
      if (done_a) begin
        checkOutput("a_busy_at_done", 32'(busy_a), 32'd0);
        if (done_qa.size() == 0) flagFail("a_unexpected_done");
        else begin
          exp_n = done_qa.pop_front();
          checkOutput("a_frames_per_done", 32'(frames_a), 32'(exp_n));
          if (exp_n > 0) begin
`ifdef DAC_LDAC_EN
            checkOutput("a_done_after_sync", 32'(since_rise_a), 32'd6);
            checkOutput("a_ldac_low_cycles", 32'(ldac_cnt_a), 32'd2);
`else
            checkOutput("a_done_after_sync", 32'(since_rise_a), 32'd4);
`endif
          end
        end
        frames_a = 0; ldac_cnt_a = 0; tot_done_a++;
      end
    end
    sync_aq = sync_a;
    sclk_aq = sclk_a;
  end

  // Monitor for instance b: also checks every sclk level lasts CLK_DIV=3 cycles.
  int          low_b, nb_b, lvl_b;
  logic [15:0] rx_b;
  logic        sync_bq = 1'b1, sclk_bq = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      low_b = 0; nb_b = 0; lvl_b = 0; rx_b = '0;
    end else begin
      if (done_b) tot_done_b++;
      if (sync_bq && !sync_b) begin
        low_b = 0; nb_b = 0; lvl_b = 0; rx_b = '0;
      end
      if (!sync_b) begin
        low_b++;
        if (sclk_b != sclk_bq && !sync_bq) begin
          checkOutput("b_sclk_level_len", 32'(lvl_b), 32'd3);
          lvl_b = 1;
        end else lvl_b++;
        if (sclk_bq && !sclk_b) begin
          rx_b = {rx_b[14:0], din_b};
          nb_b++;
        end
      end else if (!sync_bq) begin
        checkOutput("b_sclk_level_len", 32'(lvl_b), 32'd3);
        checkOutput("b_sync_low_cycles", 32'(low_b), 32'd96);
        checkOutput("b_sclk_falls", 32'(nb_b), 32'd16);
        if (exp_qb.size() == 0) flagFail("b_unexpected_frame");
        else checkOutput("b_frame_bits", 32'(rx_b), 32'(exp_qb.pop_front()));
        tot_frames_b++;
      end
    end
    sync_bq = sync_b;
    sclk_bq = sclk_b;
  end

  initial begin
    int i;
    // Reset values while rst is held
    @(negedge clk);
    checkOutput("rst_sync", 32'(sync_a), 32'd1);
    checkOutput("rst_sclk", 32'(sclk_a), 32'd1);
    checkOutput("rst_din", 32'(din_a), 32'd0);
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_done", 32'(done_a), 32'd0);
    checkOutput("rst_sync_b", 32'(sync_b), 32'd1);
`ifdef DAC_LDAC_EN
    checkOutput("rst_ldac_n", 32'(ldac_a), 32'd1);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single channel 0, then both channels, then a few other patterns
    applyStimulus(16'h3CA5, 2'b01, 1, 16'h10A5, 16'h0000); waitIdleA("a_timeout_ch0");
    applyStimulus(16'h3CA5, 2'b11, 2, 16'h10A5, 16'h903C); waitIdleA("a_timeout_both");
    applyStimulus(16'h5AFF, 2'b10, 1, 16'h905A, 16'h0000); waitIdleA("a_timeout_ch1");
    applyStimulus(16'h0081, 2'b11, 2, 16'h1081, 16'h9000); waitIdleA("a_timeout_edge");

    // Empty mask: busy for one cycle, then done, bus untouched
    applyStimulus(16'h3CA5, 2'b00, 0, 16'h0000, 16'h0000);
    checkOutput("m0_busy_first", 32'(busy_a), 32'd1);
    checkOutput("m0_done_first", 32'(done_a), 32'd0);
    checkOutput("m0_sync", 32'(sync_a), 32'd1);
    @(negedge clk);
    checkOutput("m0_busy_second", 32'(busy_a), 32'd0);
    checkOutput("m0_done_second", 32'(done_a), 32'd1);
    checkOutput("m0_sclk", 32'(sclk_a), 32'd1);
    repeat (3) @(negedge clk);

    // Start and input changes mid-frame must not disturb the transfer
    applyStimulus(16'h3CA5, 2'b01, 1, 16'h10A5, 16'h0000);
    repeat (10) @(negedge clk);
    data_a  = 16'h0000;
    mask_a  = 2'b11;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    waitIdleA("a_timeout_midframe");
    repeat (60) @(negedge clk);

    // Reset during bit 7 of a frame
    @(negedge clk);
    data_a  = 16'h3CA5;
    mask_a  = 2'b01;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_sync", 32'(sync_a), 32'd1);
    checkOutput("midrst_sclk", 32'(sclk_a), 32'd1);
    checkOutput("midrst_busy", 32'(busy_a), 32'd0);
    checkOutput("midrst_done", 32'(done_a), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(16'h3CA5, 2'b01, 1, 16'h10A5, 16'h0000); waitIdleA("a_timeout_after_rst");

    // Slow clock divider, 12-bit samples, 4-bit control
    exp_qb.push_back(16'h39E1);
    exp_qb.push_back(16'hC5A7);
    @(negedge clk);
    data_b  = 24'h5A7_9E1;
    mask_b  = 2'b11;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    i = 0;
    while (busy_b === 1'b1 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    if (busy_b !== 1'b0) flagFail("b_timeout");
    repeat (5) @(negedge clk);

    checkOutput("a_total_frames", 32'(tot_frames_a), 32'(exp_tot_frames));
    checkOutput("a_total_done", 32'(tot_done_a), 32'(exp_tot_done));
    checkOutput("a_queue_drained", 32'(exp_qa.size()), 32'd0);
    checkOutput("b_total_frames", 32'(tot_frames_b), 32'd2);
    checkOutput("b_total_done", 32'(tot_done_b), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
